mul4_share_sched: RTL and testbench

- Scheduler that shares one combinational 4x4 multiplier (mul4 instance outside this block) between NREQ requesters.
- Each requester submits an 8x8 unsigned multiply.
- Block arbitrates round-robin and sequences four partial products through the shared multiplier.
- Accumulates a 16-bit result and returns it with a one-cycle done pulse.
- Sits between the Monte Carlo sampling FSMs and the single multiplier, so several samplers can run without duplicating the multiplier.

---
 rtl/mul4_share_sched.sv | 151 +++++++++++++++
 tb/tb_mul4_share_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mul4_share_sched.sv
// Round-robin scheduler sharing one 4x4 multiplier across NREQ 8x8 jobs.
// Optional squaring path (5-cycle jobs) enabled by MUL_SCHED_SQUARE_EN.
module mul4_share_sched #(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] a_in,
  input  logic [8*NREQ-1:0] b_in,
`ifdef MUL_SCHED_SQUARE_EN
  input  logic [NREQ-1:0]   sq,
`endif
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [NREQ-1:0]   done,
  output logic [15:0]       result,
  output logic [3:0]        mul_a,
  output logic [3:0]        mul_b,
  input  logic [7:0]        mul_c
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE, S_P0, S_P1, S_P2, S_P3, S_DONE
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [7:0]      r_opa;
  logic [7:0]      r_opb;
  logic [15:0]     r_acc;
  logic [NREQ-1:0] r_gnt;
  logic            r_busy;
  logic [NREQ-1:0] r_done;
  logic [15:0]     r_result;
  logic            r_sq;

  logic            w_hit;
  logic [PW-1:0]   w_sel;
  int              w_idx;
  logic [15:0]     w_pp;
  logic [7:0]      w_a;
  logic [7:0]      w_b;
  logic            w_sq;
  logic [NREQ-1:0] w_onehot;

  // First set request at or above the pointer, wrapping around
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    w_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NREQ;
      if (!w_hit && req[w_idx]) begin
        w_hit = 1'b1;
        w_sel = PW'(w_idx);
      end
    end
  end

  assign w_a      = a_in[8*w_sel +: 8];
  assign w_b      = b_in[8*w_sel +: 8];
  assign w_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_sel;
  assign w_pp     = {8'h00, mul_c};

`ifdef MUL_SCHED_SQUARE_EN
  assign w_sq = sq[w_sel];
`else
  assign w_sq = 1'b0;
`endif

  always_comb begin
    mul_a = 4'h0;
    mul_b = 4'h0;
    case (r_state)
      S_P0: begin mul_a = r_opa[3:0]; mul_b = r_opb[3:0]; end
      S_P1: begin mul_a = r_opa[7:4]; mul_b = r_opb[3:0]; end
      S_P2: begin mul_a = r_opa[3:0]; mul_b = r_opb[7:4]; end
      S_P3: begin mul_a = r_opa[7:4]; mul_b = r_opb[7:4]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_opa    <= 8'h00;
      r_opb    <= 8'h00;
      r_acc    <= 16'h0000;
      r_gnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= '0;
      r_result <= 16'h0000;
      r_sq     <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_opa   <= w_a;
            // A square job reuses opA in the B lanes so b_in is ignored
            r_opb   <= w_sq ? w_a : w_b;
            r_sq    <= w_sq;
            r_gnt   <= w_onehot;
            r_busy  <= 1'b1;
            r_ptr   <= PW'((int'(w_sel) + 1) % NREQ);
            r_state <= S_P0;
          end
        end
        S_P0: begin
          r_acc   <= w_pp;
          r_state <= S_P1;
        end
        S_P1: begin
          // Cross terms are equal when squaring: one product, doubled
          if (r_sq) begin
            r_acc   <= r_acc + (w_pp << 5);
            r_state <= S_P3;
          end else begin
            r_acc   <= r_acc + (w_pp << 4);
            r_state <= S_P2;
          end
        end
        S_P2: begin
          r_acc   <= r_acc + (w_pp << 4);
          r_state <= S_P3;
        end
        S_P3: begin
          r_result <= r_acc + (w_pp << 8);
          r_done   <= r_gnt;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt    = r_gnt;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_mul4_share_sched.sv
// Directed self-checking bench for mul4_share_sched (NREQ=2).
// Square-path steps run only when MUL_SCHED_SQUARE_EN is defined.
module tb_mul4_share_sched;

  localparam int NREQ = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] a_in;
  logic [8*NREQ-1:0] b_in;
  logic [NREQ-1:0]   tb_sq;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic [NREQ-1:0]   done;
  logic [15:0]       result;
  logic [3:0]        mul_a;
  logic [3:0]        mul_b;
  logic [7:0]        mul_c;

  int checks = 0;
  int errors = 0;

  mul4_share_sched #(.NREQ(NREQ)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .a_in   (a_in),
    .b_in   (b_in),
`ifdef MUL_SCHED_SQUARE_EN
    .sq     (tb_sq),
`endif
    .gnt    (gnt),
    .busy   (busy),
    .done   (done),
    .result (result),
    .mul_a  (mul_a),
    .mul_b  (mul_b),
    .mul_c  (mul_c)
  );

  // External shared 4x4 multiplier
  assign mul_c = {4'h0, mul_a} * {4'h0, mul_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Grant edge starts P0; done is seen lat cycles after the first job cycle
  task automatic run_job(input int idx, input logic [7:0] a,
                         input logic [7:0] b, input logic s,
                         input logic [15:0] exp, input int lat,
                         input bit perturb, input string tag);
    int n;
    bit seen;
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << idx;
    a_in[8*idx +: 8] = a;
    b_in[8*idx +: 8] = b;
    tb_sq[idx] = s;
    req[idx] = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (gnt[idx]) seen = 1;
    end
    chk({tag, "_granted"}, 32'(seen), 32'd1);
    chk({tag, "_gnt"}, 32'(gnt), 32'(oh));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_p0_mula"}, 32'(mul_a), 32'(a[3:0]));
    chk({tag, "_p0_mulb"}, 32'(mul_b), 32'(s ? a[3:0] : b[3:0]));
    n = 0;
    seen = 0;
    while (n < 10 && !seen) begin
      @(negedge clk);
      n++;
      if (perturb && n == 1) begin
        a_in[8*idx +: 8] = ~a;
        b_in[8*idx +: 8] = ~b;
      end
      if (done != '0) seen = 1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_done"}, 32'(done), 32'(oh));
    chk({tag, "_result"}, 32'(result), 32'(exp));
    chk({tag, "_gnt_in_done"}, 32'(gnt), 32'(oh));
    chk({tag, "_mula_done"}, 32'(mul_a), 32'd0);
    req[idx] = 1'b0;
    @(negedge clk);
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    chk({tag, "_gnt_clr"}, 32'(gnt), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_held"}, 32'(result), 32'(exp));
  endtask

  initial begin
    logic [NREQ-1:0] glist [4];
    logic [NREQ-1:0] dlist [2];
    logic [15:0]     rlist [2];
    logic [NREQ-1:0] prev;
    int ng;
    int nd;
    int n;
    bit seen;

    rst = 1'b1; req = '0; a_in = '0; b_in = '0; tb_sq = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_mul", 32'({mul_a, mul_b}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_job(0, 8'h12, 8'h34, 1'b0, 16'h03A8, 4, 0, "single");
    run_job(0, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 4, 0, "ffxff");
    run_job(1, 8'h00, 8'hA5, 1'b0, 16'h0000, 4, 0, "zero");
    run_job(1, 8'h80, 8'h02, 1'b0, 16'h0100, 4, 0, "x80x02");
    run_job(1, 8'h12, 8'h34, 1'b0, 16'h03A8, 4, 1, "stable");

    // Contention from reset: both requesters held high
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a_in = {8'h0F, 8'h10};
    b_in = {8'h11, 8'h10};
    req = 2'b11;
    ng = 0; nd = 0; prev = '0;
    for (int i = 0; i < 60 && ng < 4; i++) begin
      @(negedge clk);
      if (gnt != '0 && prev == '0) begin
        glist[ng] = gnt;
        ng++;
      end
      if (done != '0 && nd < 2) begin
        dlist[nd] = done;
        rlist[nd] = result;
        nd++;
      end
      prev = gnt;
    end
    req = '0;
    chk("cont_ngrants", 32'(ng), 32'd4);
    chk("cont_ndone", 32'(nd), 32'd2);
    if (ng == 4) begin
      chk("cont_g0", 32'(glist[0]), 32'b01);
      chk("cont_g1", 32'(glist[1]), 32'b10);
      chk("cont_g2", 32'(glist[2]), 32'b01);
      chk("cont_g3", 32'(glist[3]), 32'b10);
    end
    if (nd == 2) begin
      chk("cont_d0", 32'(dlist[0]), 32'b01);
      chk("cont_r0", 32'(rlist[0]), 32'h0100);
      chk("cont_d1", 32'(dlist[1]), 32'b10);
      chk("cont_r1", 32'(rlist[1]), 32'h00FF);
    end
    repeat (8) @(negedge clk);
    chk("cont_idle", 32'(busy), 32'd0);

    // Reset during P2 aborts silently; held req restarts the job
    a_in[7:0] = 8'h12;
    b_in[7:0] = 8'h34;
    req[0] = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (gnt[0]) seen = 1;
    end
    chk("rmid_granted", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rmid_gnt", 32'(gnt), 32'd0);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_done", 32'(done), 32'd0);
    chk("rmid_result", 32'(result), 32'd0);
    chk("rmid_mul", 32'({mul_a, mul_b}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0; seen = 0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      n++;
      if (done != '0) seen = 1;
    end
    chk("rmid_redone", 32'(seen), 32'd1);
    chk("rmid_reresult", 32'(result), 32'h03A8);
    chk("rmid_relatency", 32'(n), 32'd5);
    req = '0;
    repeat (2) @(negedge clk);

`ifdef MUL_SCHED_SQUARE_EN
    run_job(0, 8'hB7, 8'h00, 1'b1, 16'h82D1, 3, 0, "square");
    run_job(1, 8'hB7, 8'hB7, 1'b0, 16'h82D1, 4, 0, "sq_off");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
